// File: rtl/datamem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// datamem_port_arbiter_if
// Bus bundle between the two data-memory requesters, the port arbiter and the
// byte-wide single-port data memory.
//   rN_valid/write/size/addr/wdata : request from requester N (held to ready)
//   rN_ready/done/rdata            : acceptance, completion pulse, load data
//   mem_en/we/addr/wdata           : one byte-wide memory cycle
//   mem_rdata                      : read byte, valid the cycle after a read
// Modports: slave = the arbiter, master = requesters plus memory.
// ---------------------------------------------------------------------------
interface datamem_port_arbiter_if #(
    parameter int AW = 10
);
    logic          r0_valid;
    logic          r0_write;
    logic [1:0]    r0_size;
    logic [AW-1:0] r0_addr;
    logic [31:0]   r0_wdata;
    logic          r0_ready;
    logic          r0_done;
    logic [31:0]   r0_rdata;

    logic          r1_valid;
    logic          r1_write;
    logic [1:0]    r1_size;
    logic [AW-1:0] r1_addr;
    logic [31:0]   r1_wdata;
    logic          r1_ready;
    logic          r1_done;
    logic [31:0]   r1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  r0_valid, r0_write, r0_size, r0_addr, r0_wdata,
        output r0_ready, r0_done, r0_rdata,
        input  r1_valid, r1_write, r1_size, r1_addr, r1_wdata,
        output r1_ready, r1_done, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output r0_valid, r0_write, r0_size, r0_addr, r0_wdata,
        input  r0_ready, r0_done, r0_rdata,
        output r1_valid, r1_write, r1_size, r1_addr, r1_wdata,
        input  r1_ready, r1_done, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/datamem_port_arbiter.sv
// ---------------------------------------------------------------------------
// datamem_port_arbiter
// Shares the byte-wide single-port data memory between requester 0 (core
// load/store path) and requester 1 (debug/loader port). A granted access of
// 1, 2 or 4 bytes is issued as consecutive little-endian byte cycles; load
// data is assembled and returned with a one-cycle done pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : datamem_port_arbiter_if.slave (requester and memory signals)
// Parameters:
//   AW         : byte-address width of the data memory
//   FIXED_PRIO : 0 = round-robin, 1 = requester 0 always wins
// ---------------------------------------------------------------------------
module datamem_port_arbiter #(
    parameter int AW         = 10,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    datamem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the final byte for a size code; code 3 behaves as a word.
    function automatic logic [1:0] size_to_last_idx(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            2'd0:    last = 2'd0;
            2'd1:    last = 2'd1;
            default: last = 2'd3;
        endcase
        return last;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

    state_t        state_q;
    logic          last_gnt_q;   // 1 = requester 1 was granted most recently
    logic          winner_q;     // requester owning the current access
    logic          write_q;
    logic [1:0]    last_idx_q;
    logic [1:0]    idx_q;        // byte issued to memory in the current BUSY cycle
    logic [AW-1:0] base_q;
    logic [31:0]   wdata_q;
    logic [31:0]   buf_q;        // load bytes assembled so far
    logic [31:0]   r0_rdata_q;
    logic [31:0]   r1_rdata_q;
    logic          done_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_wdata_q;

    logic          gnt0_s;
    logic          gnt1_s;
    logic          req_write_s;
    logic [1:0]    req_size_s;
    logic [AW-1:0] req_addr_s;
    logic [31:0]   req_wdata_s;
    logic [31:0]   rd_asm_s;
    logic [1:0]    idx_d;
    logic [AW-1:0] mem_addr_d;

    // Grant decision; only evaluated while IDLE, the loser simply sees no ready.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.r0_valid && (FIXED_PRIO || !bus.r1_valid || last_gnt_q)) begin
                gnt0_s = 1'b1;
            end else if (bus.r1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Request fields of the winning requester.
    always_comb begin
        req_write_s = bus.r0_write;
        req_size_s  = bus.r0_size;
        req_addr_s  = bus.r0_addr;
        req_wdata_s = bus.r0_wdata;
        if (gnt1_s) begin
            req_write_s = bus.r1_write;
            req_size_s  = bus.r1_size;
            req_addr_s  = bus.r1_addr;
            req_wdata_s = bus.r1_wdata;
        end else begin
            req_write_s = bus.r0_write;
            req_size_s  = bus.r0_size;
            req_addr_s  = bus.r0_addr;
            req_wdata_s = bus.r0_wdata;
        end
    end

    // Next byte index/address and the load word including the final byte.
    always_comb begin
        idx_d      = idx_q + 2'd1;
        mem_addr_d = base_q + AW'(idx_d);
        rd_asm_s   = put_byte(buf_q, last_idx_q, bus.mem_rdata);
    end

    // Access sequencer FSM with registered memory strobes and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            winner_q    <= 1'b0;
            write_q     <= 1'b0;
            last_idx_q  <= 2'd0;
            idx_q       <= 2'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            r0_rdata_q  <= 32'd0;
            r1_rdata_q  <= 32'd0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (gnt0_s || gnt1_s) begin
                        winner_q    <= gnt1_s;
                        last_gnt_q  <= gnt1_s;
                        write_q     <= req_write_s;
                        last_idx_q  <= size_to_last_idx(req_size_s);
                        idx_q       <= 2'd0;
                        base_q      <= req_addr_s;
                        wdata_q     <= req_wdata_s;
                        buf_q       <= 32'd0;
                        // First byte is presented on the very first BUSY cycle.
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= req_write_s;
                        mem_addr_q  <= req_addr_s;
                        mem_wdata_q <= req_wdata_s[7:0];
                        state_q     <= ST_BUSY;
                    end else begin
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= 8'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Read byte from the previous cycle's issue lands now.
                    if (!write_q && (idx_q != 2'd0)) begin
                        buf_q <= put_byte(buf_q, idx_q - 2'd1, bus.mem_rdata);
                    end else begin
                        buf_q <= buf_q;
                    end
                    if (idx_q == last_idx_q) begin
                        done_q      <= 1'b1;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= 8'd0;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q       <= idx_d;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= get_byte(wdata_q, idx_d);
                        state_q     <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (!write_q) begin
                        if (winner_q) begin
                            r1_rdata_q <= rd_asm_s;
                        end else begin
                            r0_rdata_q <= rd_asm_s;
                        end
                    end else begin
                        r0_rdata_q <= r0_rdata_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.r0_ready  = gnt0_s;
    assign bus.r1_ready  = gnt1_s;
    assign bus.r0_done   = done_q & ~winner_q;
    assign bus.r1_done   = done_q & winner_q;
    // The last load byte only arrives during DONE, so it is merged in directly
    // while done is high and held in the per-requester register afterwards.
    assign bus.r0_rdata  = (done_q && !write_q && !winner_q) ? rd_asm_s : r0_rdata_q;
    assign bus.r1_rdata  = (done_q && !write_q && winner_q)  ? rd_asm_s : r1_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_datamem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_datamem_port_arbiter
// Scoreboard bench: each accepted request pushes its expected completion
// (requester, cycle, load data) and expected memory byte writes; the monitor
// pops and compares when the DUT produces them. A second instance with
// FIXED_PRIO=1 checks starvation of requester 1.
// ---------------------------------------------------------------------------
module tb_datamem_port_arbiter;
    localparam int AW = 10;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t sb[$];
    wr_t  wq[$];
    int   glog[$];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] mem_rd = 8'h00;

    always #5 clk = ~clk;

    // Cycle counter used to time the done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    datamem_port_arbiter_if #(.AW(AW)) bus ();
    datamem_port_arbiter_if #(.AW(AW)) bus_fp ();

    datamem_port_arbiter #(.AW(AW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    datamem_port_arbiter #(.AW(AW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp)
    );

    assign bus.mem_rdata    = mem_rd;
    assign bus_fp.mem_rdata = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        else if (sz == 2'd1) return 2;
        else return 4;
    endfunction

    // Byte-wide memory: synchronous write, read data one cycle after the strobe.
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
                else mem_rd <= mem[bus.mem_addr];
            end
        end
    end

    task automatic accept(input int id, input logic w, input logic [1:0] sz,
                          input logic [AW-1:0] a, input logic [31:0] d);
        exp_t e;
        wr_t x;
        logic [AW-1:0] ad;
        int n;
        n = nbytes_of(sz);
        e.id = id; e.wr = w; e.data = 32'd0; e.due = cyc + n + 1;
        for (int i = 0; i < n; i++) begin
            ad = a + AW'(i);
            if (w) begin
                x.addr = ad; x.data = d[8*i +: 8];
                wq.push_back(x);
                ref_mem[ad] = d[8*i +: 8];
            end else begin
                e.data[8*i +: 8] = ref_mem[ad];
            end
        end
        sb.push_back(e);
        glog.push_back(id);
    endtask

    // Monitor: records acceptances, checks byte writes and done pulses.
    initial begin
        exp_t e;
        wr_t x;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                sb.delete();
                wq.delete();
            end else begin
                if (bus.r0_valid && bus.r0_ready)
                    accept(0, bus.r0_write, bus.r0_size, bus.r0_addr, bus.r0_wdata);
                if (bus.r1_valid && bus.r1_ready)
                    accept(1, bus.r1_write, bus.r1_size, bus.r1_addr, bus.r1_wdata);
                if (bus.mem_en && bus.mem_we) begin
                    if (wq.size() == 0) begin
                        check_val("spurious_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        x = wq.pop_front();
                        check_val("wr_addr", 32'(bus.mem_addr), 32'(x.addr));
                        check_val("wr_data", 32'(bus.mem_wdata), 32'(x.data));
                    end
                end
                if (bus.r0_done || bus.r1_done) begin
                    if (sb.size() == 0) begin
                        check_val("spurious_done", {30'd0, bus.r1_done, bus.r0_done}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("done_who", {30'd0, bus.r1_done, bus.r0_done},
                                  (e.id == 1) ? 32'd2 : 32'd1);
                        check_val("done_cycle", cyc, e.due);
                        if (!e.wr)
                            check_val("rdata", (e.id == 1) ? bus.r1_rdata : bus.r0_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic drive(input int id, input logic v, input logic w, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [31:0] d);
        if (id == 0) begin
            bus.r0_valid = v; bus.r0_write = w; bus.r0_size = sz;
            bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_valid = v; bus.r1_write = w; bus.r1_size = sz;
            bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    // Present a request, hold it until ready, then drop valid the next cycle.
    task automatic req(input int id, input logic w, input logic [1:0] sz,
                       input logic [AW-1:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(id, 1'b1, w, sz, a, d);
        for (int k = 0; k < 60 && !got; k++) begin
            #2;
            if ((id == 0) ? bus.r0_ready : bus.r1_ready) got = 1'b1;
            else @(negedge clk);
        end
        check_val("granted", {31'd0, got}, 32'd1);
        @(negedge clk);
        drive(id, 1'b0, w, sz, a, d);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        check_val("drain", sb.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val(tag, {26'd0, bus.r0_ready, bus.r1_ready, bus.r0_done, bus.r1_done,
                        bus.mem_en, bus.mem_we}, 32'd0);
        check_val({tag, "_r0_rdata"}, bus.r0_rdata, 32'd0);
        check_val({tag, "_r1_rdata"}, bus.r1_rdata, 32'd0);
        check_val({tag, "_mem_bus"}, {14'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int g0;
        int fg0;
        int fg1;
        bit hit;
        drive(0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
        bus_fp.r0_valid = 1'b0; bus_fp.r0_write = 1'b0; bus_fp.r0_size = 2'd0;
        bus_fp.r0_addr = '0; bus_fp.r0_wdata = 32'd0;
        bus_fp.r1_valid = 1'b0; bus_fp.r1_write = 1'b0; bus_fp.r1_size = 2'd0;
        bus_fp.r1_addr = '0; bus_fp.r1_wdata = 32'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Word write by the loader port, then word and byte reads by the core.
        req(1, 1'b1, 2'd2, 10'h010, 32'hA1B2C3D4);
        wait_done();
        check_val("mem_010_013", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]},
                  32'hA1B2C3D4);
        req(0, 1'b0, 2'd2, 10'h010, 32'd0);
        wait_done();
        req(0, 1'b0, 2'd0, 10'h012, 32'd0);
        wait_done();

        // Half access wrapping past the top of memory.
        req(1, 1'b1, 2'd1, 10'h3FF, 32'h0000BEEF);
        wait_done();
        check_val("mem_wrap", {16'd0, mem[10'h000], mem[10'h3FF]}, 32'h0000BEEF);
        req(1, 1'b0, 2'd1, 10'h3FF, 32'd0);
        wait_done();

        // Fixed priority: both held valid, requester 1 starves.
        @(negedge clk);
        bus_fp.r0_valid = 1'b1;
        bus_fp.r1_valid = 1'b1;
        fg0 = 0;
        fg1 = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (bus_fp.r0_ready) fg0++;
            if (bus_fp.r1_ready) fg1++;
            @(negedge clk);
        end
        bus_fp.r0_valid = 1'b0;
        bus_fp.r1_valid = 1'b0;
        check_val("fp_r0_grants", fg0, 32'd10);
        check_val("fp_r1_grants", fg1, 32'd0);

        // Round-robin: both requesting continuously, last grant was requester 1.
        g0 = glog.size();
        fork
            begin
                for (int k = 0; k < 3; k++) req(0, 1'b0, 2'd0, AW'(16 + k), 32'd0);
            end
            begin
                for (int j = 0; j < 3; j++) req(1, 1'b0, 2'd0, AW'(17 + j), 32'd0);
            end
        join
        wait_done();
        check_val("rr_count", glog.size() - g0, 32'd6);
        for (int k = 0; k < 6; k++) check_val("rr_order", glog[g0 + k], k % 2);

        // Reset during the third byte of a word write.
        req(0, 1'b1, 2'd2, 10'h020, 32'h11223344);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            #2;
            if (bus.mem_en && bus.mem_addr == 10'h022) begin
                hit = 1'b1;
                reset = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check_val("rst_hit", {31'd0, hit}, 32'd1);
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_val("rst_mem_lo", {16'd0, mem[10'h021], mem[10'h020]}, 32'h00003344);
        check_val("rst_mem_hi", {24'd0, mem[10'h023]}, 32'd0);
        req(1, 1'b0, 2'd1, 10'h020, 32'd0);
        wait_done();

        // Valid drops right after ready; the word read still completes.
        req(0, 1'b0, 2'd2, 10'h010, 32'd0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datamem_port_arbiter.md
Name: datamem_port_arbiter

Overview:
- Shares the byte-wide, single-port data memory between two requesters: requester 0 is the core load/store path, requester 1 is the debug/loader port used by benches to preload or inspect memory.
- Arbitrates between them, then sequences each byte, halfword or word access into consecutive 8-bit memory cycles.
- Returns assembled little-endian read data with a one-cycle done pulse.
- Sits between the riscv datapath and the data memory.

Parameters:
- AW, 10, byte-address width of the data memory.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- r0_valid / r1_valid  in  1  request pending; held until rN_ready.
- r0_write / r1_write  in  1  1 = store, 0 = load.
- r0_size / r1_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- r0_addr / r1_addr  in  AW  byte base address.
- r0_wdata / r1_wdata  in  32  store data; byte 0 is bits [7:0].
- r0_ready / r1_ready  out  1  combinational acceptance pulse in IDLE.
- r0_done / r1_done  out  1  one-cycle completion pulse.
- r0_rdata / r1_rdata  out  32  zero-extended load data; valid while rN_done=1, held afterwards.
- mem_en  out  1  memory cycle strobe.
- mem_we  out  1  byte write enable.
- mem_addr  out  AW  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid the cycle after an mem_en=1, mem_we=0 cycle.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE, all outputs 0, rdata registers 0.
  - Round-robin pointer favours r0.
  - Memory bytes already written stay written.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any valid, pick the winner and assert its rN_ready the same cycle.
  - Latch write, size, addr and wdata. Set nbytes = 1/2/4/4 for size 0/1/2/3 and idx = 0. Go to BUSY.
  - Nothing issued to memory in IDLE.
- Arbitration:
  - FIXED_PRIO=1: r0 wins.
  - Round-robin: when both are valid, the requester not granted last wins. A lone valid always wins.
  - The pointer updates only on a grant.
- BUSY, each cycle:
  - mem_en=1, mem_we=latched write, mem_addr=(base+idx) mod 2^AW, mem_wdata=wdata byte idx.
  - For reads, mem_rdata is captured into rdata byte idx-1 when idx>0.
  - idx increments. After the byte with idx=nbytes-1 is issued, go to DONE.
- DONE:
  - For reads, capture the last byte (idx nbytes-1) from mem_rdata.
  - mem_en=0; pulse the winner's rN_done with rdata visible. Bytes not read are 0.
  - Go to IDLE. New arbitration happens the next cycle; there is no back-to-back grant in DONE.
- Latency from ready cycle (T) to done: T+nbytes+1 (byte 2, half 3, word 4+1=5).
- Throughput: one access per nbytes+2 cycles.
- Misaligned addresses are legal: bytes are sequential, address wraps at 2^AW.
- Dropping valid after ready does not abort; the transfer completes and done still pulses.
- Dropping valid before ready withdraws the request.
- The loser's ready stays 0; its inputs must be held until its own ready.
- Reset mid-BUSY:
  - State returns to IDLE immediately; no done pulse.
  - Bytes already written remain; rdata clears.

Test Plan:
- Reset, then r1 word write addr 0x010, wdata 0xA1B2C3D4 → mem writes: 0x010=D4, 0x011=C3, 0x012=B2, 0x013=A1 on 4 consecutive cycles; r1_done 5 cycles after r1_ready.
- r0 word read addr 0x010 after the above → r0_rdata=0xA1B2C3D4 with r0_done; byte read addr 0x012 → 0x000000B2.
- r0 and r1 valid in the same cycle, both continuously requesting, FIXED_PRIO=0 → grants alternate r0, r1, r0; with FIXED_PRIO=1 → r0 granted every time, r1 starved.
- Half write addr 0x3FF (AW=10), data 0x0000BEEF → 0x3FF=EF, 0x000=BE; half read back → 0x0000BEEF.
- reset pulsed low during the 3rd byte of a word write to 0x020 (prior contents 0) → no done pulse; 0x020/0x021 written, 0x022 possibly written, 0x023 unchanged; all outputs 0; next request accepted normally.
- r0 drops valid the cycle after r0_ready during a word read → r0_done still pulses with full data.
